fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 31 +++
 rtl/fetch_unit.sv | 77 +++++++
 tb/tb_fetch_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-fetch bus between fetch_unit and its environment.
// Groups the instruction-memory handshake, the control-unit presentation
// signals and the redirect/stall/halt controls coming back from the datapath.
//   master : the fetch unit (drives imem request, instruction, pc, counters)
//   slave  : memory + datapath side (drives ack/rdata and the control inputs)
interface fetch_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [18:0] imem_rdata;
  logic [18:0] instruction;
  logic        instr_valid;
  logic [15:0] pc;
  logic        stall;
  logic        branch_taken;
  logic        jump;
  logic [15:0] target;
  logic        halt;
  logic [15:0] retired;
  logic        halted;

  modport master (
    output imem_req, imem_addr, instruction, instr_valid, pc, retired, halted,
    input  imem_ack, imem_rdata, stall, branch_taken, jump, target, halt
  );

  modport slave (
    input  imem_req, imem_addr, instruction, instr_valid, pc, retired, halted,
    output imem_ack, imem_rdata, stall, branch_taken, jump, target, halt
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-issue instruction fetch sequencer.
// Fetches one 19-bit instruction at a time from instruction memory, presents
// it with its pc for one or more EXEC cycles, then advances pc (sequentially or
// to a redirect target) and counts retired instructions. A halt request on
// completion parks the unit in HALT until reset.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high reset
//   bus   - fetch_unit_if.master: imem_req/imem_addr/imem_ack/imem_rdata,
//           instruction/instr_valid/pc, stall/branch_taken/jump/target/halt,
//           retired/halted
module fetch_unit (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StExec  = 2'd2;
  localparam logic [1:0] StHalt  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] retired_q, retired_d;
  logic [18:0] instr_q, instr_d;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    instr_d   = instr_q;
    case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          state_d = StExec;
        end
      end
      StExec: begin
        // A stalled instruction is frozen: redirect and halt are not looked at.
        if (!bus.stall) begin
          retired_d = retired_q + 16'd1;
          pc_d      = (bus.jump || bus.branch_taken) ? bus.target : pc_q + 16'd1;
          state_d   = bus.halt ? StHalt : StFetch;
        end
      end
      default: state_d = StHalt;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      pc_q      <= 16'h0000;
      retired_q <= 16'h0000;
      instr_q   <= 19'h00000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      instr_q   <= instr_d;
    end
  end

  // Outputs decode directly from registered state so they follow reset
  // asynchronously and never glitch on input activity.
  assign bus.imem_req    = (state_q == StFetch);
  assign bus.imem_addr   = pc_q;
  assign bus.instruction = instr_q;
  assign bus.instr_valid = (state_q == StExec);
  assign bus.pc          = pc_q;
  assign bus.retired     = retired_q;
  assign bus.halted      = (state_q == StHalt);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit. The bench plays the memory
// (random ack latency, content derived from the address) and the datapath
// (random stalls, redirects), and tracks the expected pc and retired count
// per instruction.
module tb_fetch_unit;

  logic clk;
  logic reset;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  logic [15:0] exp_pc;
  logic [15:0] exp_ret;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [18:0] mem_word(input logic [15:0] a);
    return {a[2:0], a} ^ 19'h2a5a5;
  endfunction

  // Random activity on datapath controls; must have no effect outside EXEC.
  task automatic noise();
    bus.stall        = 1'($urandom);
    bus.jump         = 1'($urandom);
    bus.branch_taken = 1'($urandom);
    bus.halt         = 1'($urandom);
    bus.target       = 16'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_pc"}, 32'(bus.pc), 32'h0);
    check_eq({tag, "_instr"}, 32'(bus.instruction), 32'h0);
    check_eq({tag, "_retired"}, 32'(bus.retired), 32'h0);
    check_eq({tag, "_valid"}, 32'(bus.instr_valid), 32'h0);
    check_eq({tag, "_req"}, 32'(bus.imem_req), 32'h0);
    check_eq({tag, "_halted"}, 32'(bus.halted), 32'h0);
  endtask

  // Assert reset between edges, check outputs without a clock edge, release,
  // then expect one IDLE cycle followed by a fetch from address 0.
  task automatic do_reset();
    reset = 1'b1;
    bus.imem_ack = 1'b0;
    noise();
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b0;
    exp_pc  = 16'h0000;
    exp_ret = 16'h0000;
    #1;
    check_eq("idle_no_req", 32'(bus.imem_req), 32'h0);
    @(negedge clk);
    check_eq("first_req", 32'(bus.imem_req), 32'h1);
    check_eq("first_addr", 32'(bus.imem_addr), 32'h0);
  endtask

  // One instruction: fetch with dly wait cycles, hold for stalls cycles, then
  // complete with the given redirect/halt controls.
  task automatic run_instr(input logic rj, input logic rb, input logic [15:0] tgt,
                           input logic rh, input int stalls, input int dly);
    logic [18:0] w;
    int n;
    n = 0;
    bus.imem_ack = 1'b0;
    while (!bus.imem_req && n < 6) begin
      check_eq("no_valid_outside_exec", 32'(bus.instr_valid), 32'h0);
      noise();
      @(negedge clk);
      n++;
    end
    if (!bus.imem_req) begin
      check_eq("req_timeout", 32'(bus.imem_req), 32'h1);
      return;
    end
    check_eq("fetch_addr", 32'(bus.imem_addr), 32'(exp_pc));
    w = mem_word(exp_pc);
    for (int i = 0; i < dly; i++) begin
      bus.imem_ack = 1'b0;
      noise();
      @(negedge clk);
      check_eq("req_held", 32'(bus.imem_req), 32'h1);
      check_eq("addr_held", 32'(bus.imem_addr), 32'(exp_pc));
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = w;
    noise();
    @(negedge clk);
    check_eq("exec_valid", 32'(bus.instr_valid), 32'h1);
    check_eq("exec_no_req", 32'(bus.imem_req), 32'h0);
    check_eq("exec_instr", 32'(bus.instruction), 32'(w));
    check_eq("exec_pc", 32'(bus.pc), 32'(exp_pc));
    check_eq("exec_retired", 32'(bus.retired), 32'(exp_ret));
    for (int i = 0; i < stalls; i++) begin
      noise();
      bus.stall      = 1'b1;
      if (i == 1) bus.jump = 1'b1;
      bus.imem_ack   = 1'($urandom);
      bus.imem_rdata = 19'($urandom);
      @(negedge clk);
      check_eq("stall_valid", 32'(bus.instr_valid), 32'h1);
      check_eq("stall_instr", 32'(bus.instruction), 32'(w));
      check_eq("stall_pc", 32'(bus.pc), 32'(exp_pc));
      check_eq("stall_retired", 32'(bus.retired), 32'(exp_ret));
    end
    bus.stall        = 1'b0;
    bus.jump         = rj;
    bus.branch_taken = rb;
    bus.target       = tgt;
    bus.halt         = rh;
    bus.imem_ack     = 1'($urandom);
    bus.imem_rdata   = 19'($urandom);
    @(negedge clk);
    exp_pc  = (rj || rb) ? tgt : exp_pc + 16'd1;
    exp_ret = exp_ret + 16'd1;
    bus.imem_ack = 1'b0;
    check_eq("done_valid", 32'(bus.instr_valid), 32'h0);
    check_eq("done_pc", 32'(bus.pc), 32'(exp_pc));
    check_eq("done_retired", 32'(bus.retired), 32'(exp_ret));
    check_eq("done_halted", 32'(bus.halted), 32'(rh));
    check_eq("done_instr", 32'(bus.instruction), 32'(w));
    if (!rh) begin
      check_eq("next_req", 32'(bus.imem_req), 32'h1);
      check_eq("next_addr", 32'(bus.imem_addr), 32'(exp_pc));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.imem_ack     = 1'b0;
    bus.imem_rdata   = 19'h0;
    bus.stall        = 1'b0;
    bus.jump         = 1'b0;
    bus.branch_taken = 1'b0;
    bus.target       = 16'h0;
    bus.halt         = 1'b0;
    exp_pc  = 16'h0;
    exp_ret = 16'h0;
    @(negedge clk);
    do_reset();

    // Sequential fetch with one wait cycle, then zero-wait memory.
    for (int i = 0; i < 4; i++) run_instr(1'b0, 1'b0, 16'h0, 1'b0, 0, 1);
    for (int i = 0; i < 4; i++) run_instr(1'b0, 1'b0, 16'h0, 1'b0, 0, 0);

    // Redirects, including wrap at 0xFFFF and jump+branch together.
    run_instr(1'b1, 1'b0, 16'h0002, 1'b0, 0, 1);
    run_instr(1'b1, 1'b0, 16'h0040, 1'b0, 0, 1);
    run_instr(1'b1, 1'b0, 16'hffff, 1'b0, 0, 0);
    run_instr(1'b0, 1'b1, 16'h0010, 1'b0, 0, 0);
    run_instr(1'b1, 1'b0, 16'hffff, 1'b0, 0, 2);
    run_instr(1'b0, 1'b0, 16'h1234, 1'b0, 0, 1);
    run_instr(1'b1, 1'b1, 16'h0abc, 1'b0, 0, 1);

    // Four stall cycles with a jump pulsed inside, released without redirect.
    run_instr(1'b0, 1'b0, 16'h7777, 1'b0, 4, 1);

    for (int i = 0; i < 40; i++) begin
      run_instr(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 16'($urandom),
                1'b0, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    // Halt at pc 5: pc moves to 6, then everything stays frozen.
    run_instr(1'b1, 1'b0, 16'h0005, 1'b0, 0, 1);
    run_instr(1'b0, 1'b0, 16'h9999, 1'b1, 0, 1);
    for (int i = 0; i < 20; i++) begin
      noise();
      bus.imem_ack   = 1'($urandom);
      bus.imem_rdata = 19'($urandom);
      @(negedge clk);
      check_eq("halt_req", 32'(bus.imem_req), 32'h0);
      check_eq("halt_flag", 32'(bus.halted), 32'h1);
      check_eq("halt_valid", 32'(bus.instr_valid), 32'h0);
      check_eq("halt_pc", 32'(bus.pc), 32'h0006);
      check_eq("halt_retired", 32'(bus.retired), 32'(exp_ret));
    end
    do_reset();

    // Reset mid-FETCH; the ack that arrives afterwards must be ignored.
    reset = 1'b1;
    #1;
    check_reset_outputs("midfetch");
    @(negedge clk);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 19'h7ffff;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("late_ack_instr", 32'(bus.instruction), 32'h0);
    check_eq("late_ack_req", 32'(bus.imem_req), 32'h0);
    @(negedge clk);
    bus.imem_ack = 1'b0;
    check_eq("refetch_req", 32'(bus.imem_req), 32'h1);
    check_eq("refetch_addr", 32'(bus.imem_addr), 32'h0);
    check_eq("refetch_instr", 32'(bus.instruction), 32'h0);
    exp_pc  = 16'h0;
    exp_ret = 16'h0;
    run_instr(1'b0, 1'b0, 16'h0, 1'b0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
